// File: rtl/up_down_counter.sv
// Up/down counter with shadowed start/end thresholds.
// Sawtooth mode counts start..end and wraps back to start; triangle mode
// bounces between the two thresholds. Arithmetic wraps modulo 2^NUM_BITS,
// so a start above end counts through the all-ones value back to zero.
module up_down_counter #(
  parameter int NUM_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                ctrl_active_i,
  input  logic                ctrl_update_i,
  input  logic                ctrl_rst_i,
  input  logic [NUM_BITS-1:0] cfg_start_i,
  input  logic [NUM_BITS-1:0] cfg_end_i,
  input  logic                cfg_sawtooth_i,
  input  logic                event_i,
  output logic [NUM_BITS-1:0] counter_o,
  output logic                end_o,
  output logic                dir_o
);

  localparam logic [NUM_BITS-1:0] One = NUM_BITS'(1);

  logic [NUM_BITS-1:0] r_start_q, r_start_d;
  logic [NUM_BITS-1:0] r_end_q, r_end_d;
  logic                r_saw_q, r_saw_d;
  logic [NUM_BITS-1:0] counter_q, counter_d;
  logic                dir_q, dir_d;
  logic                end_q, end_d;

  logic at_end, at_start;
  assign at_end   = (counter_q == r_end_q);
  assign at_start = (counter_q == r_start_q);

  // Next-state: update beats restart beats a counting event; otherwise hold.
  always_comb begin
    r_start_d = r_start_q;
    r_end_d   = r_end_q;
    r_saw_d   = r_saw_q;
    counter_d = counter_q;
    dir_d     = dir_q;
    end_d     = 1'b0;
    if (ctrl_update_i) begin
      r_start_d = cfg_start_i;
      r_end_d   = cfg_end_i;
      r_saw_d   = cfg_sawtooth_i;
      counter_d = cfg_start_i;
      dir_d     = 1'b0;
    end else if (ctrl_rst_i) begin
      counter_d = r_start_q;
      dir_d     = 1'b0;
    end else if (ctrl_active_i && event_i) begin
      if (r_start_q == r_end_q) begin
        // Zero-length range: stay parked on start and flag every event.
        counter_d = r_start_q;
        dir_d     = 1'b0;
        end_d     = 1'b1;
      end else if (r_saw_q) begin
        dir_d = 1'b0;
        if (at_end) begin
          counter_d = r_start_q;
          end_d     = 1'b1;
        end else begin
          counter_d = counter_q + One;
        end
      end else if (!dir_q) begin
        if (at_end) begin
          dir_d     = 1'b1;
          counter_d = counter_q - One;
          end_d     = 1'b1;
        end else begin
          counter_d = counter_q + One;
        end
      end else begin
        if (at_start) begin
          dir_d     = 1'b0;
          counter_d = counter_q + One;
        end else begin
          counter_d = counter_q - One;
        end
      end
    end
  end

  // State registers; reset leaves a degenerate 0..0 sawtooth configuration.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_start_q <= '0;
      r_end_q   <= '0;
      r_saw_q   <= 1'b1;
      counter_q <= '0;
      dir_q     <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      r_start_q <= r_start_d;
      r_end_q   <= r_end_d;
      r_saw_q   <= r_saw_d;
      counter_q <= counter_d;
      dir_q     <= dir_d;
      end_q     <= end_d;
    end
  end

  assign counter_o = counter_q;
  assign dir_o     = dir_q;
  assign end_o     = end_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: directed vector table, hand-written corner
// sequences, then random traffic against a sequence-list reference model.
module tb_up_down_counter;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         act = 1'b0, upd = 1'b0, rst = 1'b0, ev = 1'b0, saw = 1'b0;
  logic [N-1:0] cs = '0, ce = '0;
  logic [N-1:0] cnt;
  logic         endp, dir;

  int total = 0;
  int bad   = 0;

  up_down_counter #(.NUM_BITS(N)) dut (
    .clk_i(clk), .rstn_i(rstn), .ctrl_active_i(act), .ctrl_update_i(upd),
    .ctrl_rst_i(rst), .cfg_start_i(cs), .cfg_end_i(ce), .cfg_sawtooth_i(saw),
    .event_i(ev), .counter_o(cnt), .end_o(endp), .dir_o(dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [N-1:0] ec, input logic ed, input logic ee);
    chk({nm, ".cnt"}, 32'(cnt), 32'(ec));
    chk({nm, ".dir"}, 32'(dir), 32'(ed));
    chk({nm, ".end"}, 32'(endp), 32'(ee));
  endtask

  // Apply inputs at the negedge, let one rising edge pass, sample at the next negedge.
  task automatic step(input logic u, input logic r, input logic a, input logic e,
                      input logic w, input logic [N-1:0] s, input logic [N-1:0] en);
    upd = u; rst = r; act = a; ev = e; saw = w; cs = s; ce = en;
    @(posedge clk);
    @(negedge clk);
    upd = 1'b0; rst = 1'b0;
  endtask

  // Reference model: the full cyclic list of (count, dir) states for the
  // current shadow config, plus an index into it.
  logic [N-1:0] m_start, m_end;
  logic         m_saw;
  logic [N-1:0] pc[$];
  bit           pd[$];
  int           idx, span;
  logic         m_endp;

  function automatic void build();
    span = int'(N'(m_end - m_start));
    pc.delete(); pd.delete();
    for (int k = 0; k <= span; k++) begin pc.push_back(N'(m_start + N'(k))); pd.push_back(1'b0); end
    if (!m_saw)
      for (int k = 1; k <= span; k++) begin pc.push_back(N'(m_end - N'(k))); pd.push_back(1'b1); end
    idx = 0;
  endfunction

  function automatic void model(input logic u, input logic r, input logic a, input logic e,
                                input logic w, input logic [N-1:0] s, input logic [N-1:0] en);
    m_endp = 1'b0;
    if (u) begin
      m_start = s; m_end = en; m_saw = w; build();
    end else if (r) begin
      idx = 0;
    end else if (a && e) begin
      m_endp = (idx == span);
      if (pc.size() == 1)              idx = 0;
      else if (m_saw)                  idx = (idx + 1) % pc.size();
      else if (idx == pc.size() - 1)   idx = 1;
      else                             idx = idx + 1;
    end
  endfunction

  typedef struct {
    logic u, r, a, e, w;
    logic [N-1:0] s, en;
    logic [N-1:0] xc;
    logic xd, xe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic u, logic r, logic a, logic e, logic w,
                              logic [N-1:0] s, logic [N-1:0] en,
                              logic [N-1:0] xc, logic xd, logic xe);
    vec_t v;
    v.u = u; v.r = r; v.a = a; v.e = e; v.w = w; v.s = s; v.en = en;
    v.xc = xc; v.xd = xd; v.xe = xe;
    return v;
  endfunction

  initial begin
    logic u, r, a, e, w;
    logic [N-1:0] s, en;

    //          u r a e w  start     end      cnt      dir end
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd0,  16'd0,   0, 1)); // degenerate after reset
    tbl.push_back(mk(0,0,1,0,0, 16'd0,   16'd0,  16'd0,   0, 0));
    tbl.push_back(mk(1,0,1,1,1, 16'd2,   16'd5,  16'd2,   0, 0)); // sawtooth 2..5
    tbl.push_back(mk(0,0,1,1,1, 16'd2,   16'd5,  16'd3,   0, 0));
    tbl.push_back(mk(0,0,1,1,1, 16'd2,   16'd5,  16'd4,   0, 0));
    tbl.push_back(mk(0,0,1,1,1, 16'd2,   16'd5,  16'd5,   0, 0));
    tbl.push_back(mk(0,0,1,1,1, 16'd2,   16'd5,  16'd2,   0, 1)); // wrap
    tbl.push_back(mk(0,0,1,1,0, 16'd9,   16'd12, 16'd3,   0, 0)); // cfg change, no update
    tbl.push_back(mk(0,0,1,1,0, 16'd9,   16'd12, 16'd4,   0, 0));
    tbl.push_back(mk(0,0,0,1,0, 16'd9,   16'd12, 16'd4,   0, 0)); // paused
    tbl.push_back(mk(0,1,0,0,0, 16'd9,   16'd12, 16'd2,   0, 0)); // restart to shadow
    tbl.push_back(mk(1,0,1,1,0, 16'd0,   16'd3,  16'd0,   0, 0)); // triangle 0..3
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd1,   0, 0));
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd2,   0, 0));
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd3,   0, 0));
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd2,   1, 1)); // turn down
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd1,   1, 0));
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd0,   1, 0));
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd1,   0, 0)); // turn up
    tbl.push_back(mk(0,0,1,1,0, 16'd0,   16'd3,  16'd2,   0, 0));
    tbl.push_back(mk(1,1,1,1,0, 16'd7,   16'd9,  16'd7,   0, 0)); // update beats rst/event
    tbl.push_back(mk(0,0,1,1,0, 16'd7,   16'd9,  16'd8,   0, 0));
    tbl.push_back(mk(0,0,1,1,0, 16'd7,   16'd9,  16'd9,   0, 0));
    tbl.push_back(mk(0,0,1,1,0, 16'd7,   16'd9,  16'd8,   1, 1));
    tbl.push_back(mk(0,1,1,1,0, 16'd7,   16'd9,  16'd7,   0, 0)); // rst beats event
    tbl.push_back(mk(1,0,1,1,1, 16'hFFFE,16'd1,  16'hFFFE,0, 0)); // wrap-around range
    tbl.push_back(mk(0,0,1,1,1, 16'hFFFE,16'd1,  16'hFFFF,0, 0));
    tbl.push_back(mk(0,0,1,1,1, 16'hFFFE,16'd1,  16'h0000,0, 0));
    tbl.push_back(mk(0,0,1,1,1, 16'hFFFE,16'd1,  16'h0001,0, 0));
    tbl.push_back(mk(0,0,1,1,1, 16'hFFFE,16'd1,  16'hFFFE,0, 1));
    tbl.push_back(mk(0,0,1,1,1, 16'hFFFE,16'd1,  16'hFFFF,0, 0));

    // Reset state
    repeat (2) @(negedge clk);
    chk_all("reset", 16'd0, 1'b0, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      step(tbl[i].u, tbl[i].r, tbl[i].a, tbl[i].e, tbl[i].w, tbl[i].s, tbl[i].en);
      chk_all($sformatf("vec%0d", i), tbl[i].xc, tbl[i].xd, tbl[i].xe);
    end

    // Pause at 4 for ten cycles, then restart from the shadowed start.
    step(1, 0, 1, 1, 1, 16'd0, 16'd9);
    repeat (4) step(0, 0, 1, 1, 1, 16'd0, 16'd9);
    chk_all("pause.pre", 16'd4, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, k[0], 1, 16'd0, 16'd9);
      chk_all("pause", 16'd4, 1'b0, 1'b0);
    end
    step(0, 1, 0, 0, 1, 16'd0, 16'd9);
    chk_all("pause.rst", 16'd0, 1'b0, 1'b0);

    // Async reset while counting down in triangle mode.
    step(1, 0, 1, 1, 0, 16'd0, 16'd3);
    repeat (4) step(0, 0, 1, 1, 0, 16'd0, 16'd3);
    chk_all("arst.pre", 16'd2, 1'b1, 1'b1);
    #2 rstn = 1'b0;
    #1 chk_all("arst.now", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 0, 16'd0, 16'd3);
      chk_all("arst.after", 16'd0, 1'b0, 1'b1);
    end

    // Random traffic against the reference model, starting from reset.
    rstn = 1'b0;
    #3 rstn = 1'b1;
    @(negedge clk);
    m_start = '0; m_end = '0; m_saw = 1'b1; build(); m_endp = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      u = ($urandom_range(0, 99) < 4);
      r = ($urandom_range(0, 99) < 3);
      a = ($urandom_range(0, 99) < 85);
      e = ($urandom_range(0, 99) < 65);
      w = $urandom_range(0, 1);
      s = ($urandom_range(0, 3) == 0) ? N'(16'hFFF8 + $urandom_range(0, 7)) : N'($urandom);
      en = N'(s + N'($urandom_range(0, 6)));
      model(u, r, a, e, w, s, en);
      step(u, r, a, e, w, s, en);
      chk_all("rand", pc[idx], pd[idx], m_endp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/up_down_counter.md
UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 The module SHALL have parameter NUM_BITS, default 16, which sets the counter and threshold width.
REQ-002 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rstn_i  input  1  reset; asynchronous, active-low.
REQ-004 ctrl_active_i  input  1  counting enable.
REQ-005 ctrl_update_i  input  1  one-cycle pulse that loads the configuration shadows and restarts the count.
REQ-006 ctrl_rst_i  input  1  one-cycle pulse that restarts the count from the shadowed start value.
REQ-007 cfg_start_i  input  NUM_BITS  start (low) threshold.
REQ-008 cfg_end_i  input  NUM_BITS  end (high) threshold.
REQ-009 cfg_sawtooth_i  input  1  mode select: 1 = sawtooth (up, wrap to start); 0 = triangle (up/down).
REQ-010 event_i  input  1  count-enable pulse, driven by the prescaler event output.
REQ-011 counter_o  output  NUM_BITS  current count, registered.
REQ-012 end_o  output  1  one-cycle pulse on the event where the count reaches the end threshold, registered.
REQ-013 dir_o  output  1  count direction: 0 = up, 1 = down, registered.

Function
REQ-014 The shadow registers r_start, r_end and r_saw SHALL load from cfg_start_i, cfg_end_i and cfg_sawtooth_i only on a cycle where ctrl_update_i=1; they SHALL hold otherwise.
REQ-015 Synchronous priority SHALL be, highest first: ctrl_update_i, ctrl_rst_i, ctrl_active_i&event_i, hold.
REQ-016 ctrl_update_i=1: counter_o <= cfg_start_i, dir_o <= 0, end_o <= 0; ctrl_active_i is ignored on this cycle.
REQ-017 ctrl_rst_i=1 (without ctrl_update_i): counter_o <= r_start, dir_o <= 0, end_o <= 0.
REQ-018 ctrl_active_i=0: counter_o and dir_o SHALL hold, and end_o <= 0 (pause, no clear).
REQ-019 When ctrl_active_i=1 and event_i=0, counter_o and dir_o SHALL hold and end_o <= 0.
REQ-020 Sawtooth mode, on an event: if counter_o==r_end, then counter_o <= r_start and end_o <= 1; otherwise counter_o <= counter_o+1 and end_o <= 0; dir_o SHALL stay 0.
REQ-021 Triangle mode, dir_o=0, on an event: if counter_o==r_end, then dir_o <= 1, counter_o <= counter_o-1 and end_o <= 1; otherwise counter_o <= counter_o+1.
REQ-022 Triangle mode, dir_o=1, on an event: if counter_o==r_start, then dir_o <= 0 and counter_o <= counter_o+1; otherwise counter_o <= counter_o-1; end_o <= 0.
REQ-023 Degenerate case r_start==r_end, in both modes: every event SHALL set end_o <= 1 with counter_o held at r_start and dir_o held at 0.
REQ-024 Increment and decrement SHALL be modulo 2^NUM_BITS; with r_start>r_end the counter SHALL wrap through 2^NUM_BITS-1 to 0 and continue until it equals r_end.
REQ-025 Latency SHALL be one clock: event_i sampled at edge n produces the new counter_o, dir_o and end_o after edge n.
REQ-026 end_o SHALL never be high for two consecutive cycles unless event_i is high on consecutive cycles.
REQ-027 A change of cfg_* without ctrl_update_i SHALL NOT affect counting.

Reset
REQ-028 While rstn_i=0: counter_o=0, dir_o=0, end_o=0, and r_start=r_end=0 with r_saw=1.
REQ-029 An assertion of rstn_i mid-count SHALL clear all state immediately, independent of clk_i.
REQ-030 After reset release, with no ctrl_update_i, each event SHALL pulse end_o per REQ-023.

Verification
REQ-031 Sawtooth wrap: update with start=2, end=5, saw=1, active=1, event every cycle -> counter 2,3,4,5,2,...; end_o=1 in the cycle after the 5->2 transition, once per period of 4 events.
REQ-032 Triangle turn: start=0, end=3, saw=0 -> counter 0,1,2,3,2,1,0,1,...; dir_o rises after the event at 3 and falls after the event at 0; end_o pulses only at the 3->2 turn.
REQ-033 Pause and restart: at count 4, drop active for 10 cycles -> counter holds 4 and end_o stays 0; then pulse ctrl_rst_i -> counter=r_start on the next cycle.
REQ-034 Priority: assert ctrl_update_i (start=7) together with ctrl_rst_i and event_i -> counter=7, dir_o=0, end_o=0.
REQ-035 Wrap-around: NUM_BITS=16, start=0xFFFE, end=1, sawtooth -> counter FFFE, FFFF, 0000, 0001, FFFE, ...; end_o pulses after the event at 0001.
REQ-036 Async reset: assert rstn_i between clock edges while counting down in triangle mode -> all outputs 0 immediately; after release, events pulse end_o with counter held at 0.
